// File: rtl/multdiv_sequencer_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: request, shared-ALU link and results.
interface multdiv_sequencer_if;
    logic        start_i;
    logic        op_div_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] alu_data_i;
    logic        alu_req_o;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_div_i, rs_data_i, rt_data_i, alu_data_i,
        input  alu_req_o, alu_operation_o, alu_a_o, alu_b_o,
        input  busy_o, done_o, div_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_div_i, rs_data_i, rt_data_i, alu_data_i,
        output alu_req_o, alu_operation_o, alu_a_o, alu_b_o,
        output busy_o, done_o, div_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller: one shift-add / restoring-divide step per cycle on the shared ALU.
module multdiv_sequencer #(
    parameter int unsigned ITER     = 32,
    parameter logic [3:0]  ALU_ADD  = 4'b0011,
    parameter logic [3:0]  ALU_SUB  = 4'b0100,
    parameter logic [3:0]  ALU_IDLE = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    multdiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     m_q, m_d;
    logic            div_q, div_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            alu_req_q, alu_req_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;

    logic [32:0]     rs_w;
    logic            carry_w;
    logic            ge_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        div_d   = div_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        rs_w    = {hi_q, lo_q[31]};
        carry_w = bus.alu_data_i < hi_q;
        ge_w    = rs_w >= {1'b0, m_q};

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    div_d = bus.op_div_i;
                    hi_d  = '0;
                    lo_d  = bus.rs_data_i;
                    m_d   = bus.rt_data_i;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (bus.op_div_i && (bus.rt_data_i == '0)) begin
                        hi_d    = bus.rs_data_i;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (div_q) begin
                    // Remainder bit 32 set means the subtract always fits, so alu_data_i is exact.
                    if (ge_w) begin
                        hi_d = bus.alu_data_i;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = rs_w[31:0];
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else if (lo_q[0]) begin
                    hi_d = {carry_w, bus.alu_data_i[31:1]};
                    lo_d = {bus.alu_data_i[0], lo_q[31:1]};
                end else begin
                    hi_d = {1'b0, hi_q[31:1]};
                    lo_d = {hi_q[0], lo_q[31:1]};
                end
                if (cnt_q == CW'(ITER - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // ALU drive is precomputed from next-cycle HI/LO so it leaves a flop yet matches HI/LO in RUN.
        if (state_d == RUN) begin
            alu_req_d = 1'b1;
            alu_op_d  = div_d ? ALU_SUB : ALU_ADD;
            alu_a_d   = div_d ? {hi_d[30:0], lo_d[31]} : hi_d;
            alu_b_d   = m_d;
        end else begin
            alu_req_d = 1'b0;
            alu_op_d  = ALU_IDLE;
            alu_a_d   = '0;
            alu_b_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
            alu_op_q  <= ALU_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            div_q     <= div_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
        end
    end

    assign bus.alu_req_o       = alu_req_q;
    assign bus.alu_operation_o = alu_op_q;
    assign bus.alu_a_o         = alu_a_q;
    assign bus.alu_b_o         = alu_b_q;
    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.div_zero_o      = dz_q;
    assign bus.hi_o            = hi_q;
    assign bus.lo_o            = lo_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_multdiv_sequencer;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_IDLE = 4'b0000;

    typedef struct {
        logic        div;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[13];

    multdiv_sequencer_if bus();

    multdiv_sequencer #(
        .ITER    (32),
        .ALU_ADD (OP_ADD),
        .ALU_SUB (OP_SUB),
        .ALU_IDLE(OP_IDLE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign bus.alu_data_i = (bus.alu_operation_o == OP_ADD) ? bus.alu_a_o + bus.alu_b_o :
                            (bus.alu_operation_o == OP_SUB) ? bus.alu_a_o - bus.alu_b_o : 32'h0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic div, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        bus.op_div_i  = div;
        bus.rs_data_i = rs;
        bus.rt_data_i = rt;
        bus.start_i   = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; walks cycles 1.. until done_o.
    task automatic finish_op(input string nm, input vec_t v, input int poke, input bit hold);
        int          cyc = 0;
        int          req = 0;
        int          ereq;
        bit          seen = 0;
        bit          badop = 0;
        bit          badbusy = 0;
        logic        dz1 = 1'b0;
        logic [3:0]  eopc;
        ereq = v.dz ? 0 : 32;
        eopc = v.div ? OP_SUB : OP_ADD;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                dz1 = bus.div_zero_o;
                if (!hold) bus.start_i = 1'b0;
            end
            if (poke > 0 && cyc == poke) begin
                bus.start_i   = 1'b1;
                bus.op_div_i  = ~v.div;
                bus.rs_data_i = 32'h7;
                bus.rt_data_i = 32'h9;
            end
            if (poke > 0 && cyc == poke + 1) bus.start_i = 1'b0;
            if (bus.alu_req_o) begin
                req++;
                if (bus.alu_operation_o !== eopc) badop = 1;
            end else if (bus.alu_operation_o !== OP_IDLE || bus.alu_a_o !== 0 || bus.alu_b_o !== 0) begin
                badop = 1;
            end
            if (bus.busy_o !== 1'b1) badbusy = 1;
            seen = (bus.done_o === 1'b1);
        end
        chk({nm, " latency"}, 64'(cyc), 64'(v.cyc));
        chk({nm, " alu_req cycles"}, 64'(req), 64'(ereq));
        chk({nm, " alu drive"}, 64'(badop), 64'(0));
        chk({nm, " busy during op"}, 64'(badbusy), 64'(0));
        chk({nm, " div_zero cycle1"}, 64'(dz1), 64'(v.dz));
        chk({nm, " hi"}, 64'(bus.hi_o), 64'(v.hi));
        chk({nm, " lo"}, 64'(bus.lo_o), 64'(v.lo));
        chk({nm, " div_zero"}, 64'(bus.div_zero_o), 64'(v.dz));
        @(negedge clk);
        chk({nm, " done pulse"}, 64'(bus.done_o), 64'(0));
        chk({nm, " busy after"}, 64'(bus.busy_o), 64'(0));
        chk({nm, " hold"}, {bus.hi_o, bus.lo_o}, {v.hi, v.lo});
    endtask

    initial begin
        bit   stray;
        vec_t m35;
        vec_t d100;
        bus.start_i   = 1'b0;
        bus.op_div_i  = 1'b0;
        bus.rs_data_i = '0;
        bus.rt_data_i = '0;

        vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{1'b0, 32'h00012345, 32'h00000010, 32'h00000000, 32'h00123450, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[3]  = '{1'b1, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 1'b0, 33};
        vecs[4]  = '{1'b1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{1'b0, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 33};
        vecs[6]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
        vecs[8]  = '{1'b1, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 33};
        vecs[9]  = '{1'b0, 32'h12345678, 32'h0,        32'd0,        32'd0,        1'b0, 33};
        vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
        vecs[11] = '{1'b1, 32'h0,        32'h0,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        vecs[12] = '{1'b0, 32'h0,        32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 33};

        #2;
        chk("reset hi/lo", {bus.hi_o, bus.lo_o}, 64'h0);
        chk("reset flags", 64'({bus.busy_o, bus.done_o, bus.div_zero_o, bus.alu_req_o}), 64'h0);
        chk("reset alu", {28'h0, bus.alu_operation_o, bus.alu_a_o | bus.alu_b_o}, {28'h0, OP_IDLE, 32'h0});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].div, vecs[i].rs, vecs[i].rt);
            finish_op($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
        end

        // New operands pulsed mid-run must not disturb the result
        launch(vecs[1].div, vecs[1].rs, vecs[1].rt);
        finish_op("poke", vecs[1], 10, 1'b0);

        // start_i held high: not taken in DONE, taken in the following IDLE cycle
        m35  = vecs[5];
        d100 = vecs[2];
        launch(m35.div, m35.rs, m35.rt);
        finish_op("b2b first", m35, 0, 1'b1);
        bus.op_div_i  = d100.div;
        bus.rs_data_i = d100.rs;
        bus.rt_data_i = d100.rt;
        finish_op("b2b second", d100, 0, 1'b0);

        // Reset mid-divide
        launch(1'b1, 32'h80000000, 32'd3);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre-abort busy", 64'(bus.busy_o), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("abort hi/lo", {bus.hi_o, bus.lo_o}, 64'h0);
        chk("abort flags", 64'({bus.busy_o, bus.done_o, bus.alu_req_o}), 64'h0);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) stray = 1;
        end
        chk("abort no done", 64'(stray), 64'(0));
        reset = 1'b1;
        launch(m35.div, m35.rs, m35.rt);
        finish_op("after abort", m35, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
